div_unit: RTL
=============

# div_unit

Parametrised multi-cycle restoring divider for the OpenMIPS execute stage. It adds DIV/DIVU support, producing quotient and remainder for the HI/LO path, and holds `ready_o` low while busy so EX can request a pipeline stall. One result per request; operands are captured at start, and the request can be annulled mid-flight on a pipeline flush.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i`  in  WIDTH  dividend; sampled with `start_i`.
- `opdata2_i`  in  WIDTH  divisor; sampled with `start_i`.
- `start_i`  in  1  request; level-held by EX until the result is consumed.
- `annul_i`  in  1  abort the current or pending operation.
- `result_o`  out  2*WIDTH  `{remainder, quotient}`; remainder → HI, quotient → LO.
- `ready_o`  out  1  result valid.

## Operation
- States: `FREE`, `BYZERO`, `ON`, `END`. Internal state: `cnt` (log2(WIDTH)+1 bits), dividend/partial-remainder register (2*WIDTH+1 bits), latched divisor, latched sign flags.
- **FREE**
  - `start_i`=1, `annul_i`=0, divisor = 0 → `BYZERO`.
  - `start_i`=1, `annul_i`=0, divisor ≠ 0 → `ON`:
    - latch operands, taking magnitudes when signed;
    - latch sign(dividend) and sign(dividend)^sign(divisor);
    - clear `cnt`.
  - Otherwise stay in `FREE`.
- **BYZERO**: load a zero result, then → `END` on the next edge.
- **ON**: one restoring step per edge.
  - Shift the partial remainder left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - `cnt`++.
  - After the WIDTH-th step → `END`. On that transition apply sign correction:
    - quotient negated if the latched signs differ;
    - remainder negated if the dividend was negative.
  - Unsigned operations apply no correction.
- **END**
  - `ready_o`=1 and `result_o` holds the result.
  - `start_i`=0 → `FREE`, with `ready_o`=0 and `result_o`=0.
  - `start_i`=1 → remain in `END`, with the result stable.
- **Annul**: `annul_i`=1 in any state other than `FREE` → `FREE` next edge, with `result_o`=0 and `ready_o`=0. `annul_i` has priority over `start_i` and over completion.
- Arithmetic rules:
  - Magnitude of the most-negative value is its own bit pattern, treated as unsigned 2^(WIDTH-1).
  - Signed most-negative / −1 → quotient = most-negative (wraps), remainder = 0.
  - Divide by zero → quotient = 0, remainder = 0 (defined, not trapped).
- Operand or `signed_div_i` changes after acceptance are ignored until the next `FREE`.

## Timing
- Reset (`rst`=0 at an edge): state `FREE`, `cnt`=0, `result_o`=0, `ready_o`=0, all internal registers 0. This takes effect from any state, including mid-operation.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Edge numbering: let edge 0 be the edge at which `start_i` is accepted in `FREE`.
  - Normal operation: iterations occur at edges 1..WIDTH. `ready_o` rises after edge WIDTH+1, so the latency is WIDTH+1 cycles after acceptance (33 for WIDTH=32).
  - Divide by zero: `ready_o` rises after edge 1.
- EX stalls while `start_i`=1 and `ready_o`=0. EX drops `start_i` in the cycle it consumes the result. `ready_o` falls after the following edge.
- Back-to-back operations: at least one `FREE` cycle separates them.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_div_i` is honoured;
  - magnitude conversion and sign-correction logic are present.
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` is ignored and every operation is unsigned;
  - no negation logic is built;
  - latency is unchanged.

## Test plan
- Unsigned, WIDTH=32: 7 / 2 → after 33 cycles `ready_o`=1, quotient=3, remainder=1. Drop `start_i` → `ready_o`=0 and `result_o`=0 next cycle.
- Signed: 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Without `DIV_SIGNED_EN`: quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero: 0x12345678 / 0 → `ready_o`=1 after 2 edges, `result_o`=0.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Abort: `annul_i` pulse at iteration 10 → `FREE` next edge, `ready_o` never rises. An immediate new 100 / 7 → quotient 14, remainder 2.
- Reset mid-operation and WIDTH=8:
  - `rst`=0 at iteration 5 → all outputs 0 and state `FREE`.
  - WIDTH=8 instance: 200 / 9 unsigned → quotient 22, remainder 2, `ready_o` after edge 9.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the execute stage; one quotient bit per cycle.
// Define DIV_SIGNED_EN to build signed support; otherwise every operation is unsigned.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    // {remainder, dividend/quotient, spare}: remainder grows into the top as quotient bits enter bit 0
    logic [2*WIDTH:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [WIDTH-1:0]   raw_quot;
    logic [WIDTH-1:0]   raw_rem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               accept;

    assign accept   = (state == FREE) && start_i && !annul_i;
    assign trial    = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    assign raw_quot = dividend[WIDTH-1:0];
    assign raw_rem  = dividend[2*WIDTH:WIDTH+1];

`ifdef DIV_SIGNED_EN
    logic neg_quot;
    logic neg_rem;

    // The most-negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    assign quot    = neg_quot ? (~raw_quot + WIDTH'(1)) : raw_quot;
    assign rem     = neg_rem  ? (~raw_rem  + WIDTH'(1)) : raw_rem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (accept) begin
            neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
        end
    end
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div_i;
    assign op1_mag = opdata1_i;
    assign op2_mag = opdata2_i;
    assign quot    = raw_quot;
    assign rem     = raw_rem;
`endif

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_nxt = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (accept && (opdata2_i != '0)) begin
                        dividend <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        divisor  <= op2_mag;
                        cnt      <= '0;
                    end
                end
                BYZERO: begin
                    dividend <= '0;
                    result_o <= '0;
                    ready_o  <= !annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (cnt != LAST_STEP) begin
                        if (trial[WIDTH]) begin
                            dividend <= {dividend[2*WIDTH-1:0], 1'b0};
                        end else begin
                            dividend <= {trial[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem, quot};
                        ready_o  <= 1'b1;
                        cnt      <= '0;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
